dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  synchronous, active-low reset.
REQ-003 req_valid  input  1  processor load/store request present.
REQ-004 req_ready  output  1  high only in IDLE; request accepted on edge where req_valid&req_ready.
REQ-005 req_we  input  1  1=store, 0=load.
REQ-006 req_size  input  2  00 byte, 01 halfword, 10 word; 11 treated as error.
REQ-007 req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend.
REQ-008 req_addr  input  32  byte address; only bits [13:0] used, [31:14] ignored.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 rsp_valid  output  1  one-cycle completion pulse; no back-pressure.
REQ-011 rsp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 rsp_err  output  1  qualified by rsp_valid; misaligned or unsupported request.
REQ-013 mem_address  output  12  word address to data memory = latched req_addr[13:2].
REQ-014 mem_data  output  32  write data to data memory.
REQ-015 mem_wren  output  1  memory write enable.
REQ-016 mem_q  input  32  memory read data, valid the cycle after an edge sampling mem_address with mem_wren=0.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, MERGE, DONE, ERR.
REQ-018 IDLE: on accept latch we/size/unsigned/addr/wdata; misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=11) -> ERR, else -> ISSUE.
REQ-019 ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0, no memory access -> IDLE.
REQ-020 ISSUE: word store drives mem_wren=1, mem_data=wdata -> DONE; loads and sub-word stores drive mem_wren=0 -> WAIT.
REQ-021 WAIT: load extracts lane per addr[1:0] (little-endian, byte0=[7:0]), extends per size/unsigned, registers result -> DONE; sub-word store merges wdata lane into mem_q -> MERGE.
REQ-022 MERGE: mem_wren=1, mem_data=merged word, same mem_address -> DONE.
REQ-023 DONE: rsp_valid=1, rsp_err=0, rsp_rdata=load result or 0 -> IDLE.
REQ-024 Latency from accept edge T: error rsp at T+1, word store T+2, load T+3, sub-word store T+4.
REQ-025 mem_wren SHALL be 0 in all states except ISSUE(word store) and MERGE, and SHALL be gated by reset_n.
REQ-026 mem_address and mem_data SHALL hold their last values while IDLE.
REQ-027 req_valid while req_ready=0 SHALL be ignored; requester must hold it until accepted.
REQ-028 Back-to-back: new request accepted in the IDLE cycle following DONE/ERR.

Reset
REQ-029 reset_n=0 at an edge: state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_address=0, mem_data=0, latched request cleared.
REQ-030 Reset mid-operation SHALL abandon the request with no response; no memory write committed on any edge where reset_n=0.

Configuration
REQ-031 Macro DMEM_LSU_SUBWORD_EN defined: byte/halfword loads and stores supported per REQ-018..REQ-022.
REQ-032 DMEM_LSU_SUBWORD_EN undefined: size 00/01 -> ERR path; MERGE state and lane logic absent; word behaviour unchanged.

Verification
REQ-033 reset_n=0 two cycles -> all outputs 0, mem_wren=0; after release req_ready=1.
REQ-034 Word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> mem_address=4, mem_wren high one cycle, load rsp at T+3 with rsp_rdata=0xDEADBEEF.
REQ-035 Byte store 0x80 at addr 0x11 over 0xDEADBEEF -> word reads 0xDEAD80EF; signed byte load 0x11 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Halfword load addr 0x13 -> rsp_valid&rsp_err at T+1, rsp_rdata=0, mem_wren never asserted.
REQ-037 Byte store with reset_n=0 on the MERGE edge -> no write, word unchanged, no rsp_valid.
REQ-038 DMEM_LSU_SUBWORD_EN undefined: byte store addr 0x10 -> rsp_err=1 at T+1, memory unchanged.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Processor request/response and data-memory bus shared by dmem_lsu and its environment.
// The slave modport is the LSU; the master modport is the processor plus memory side.
interface dmem_lsu_if;
    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    // The requester holds req_valid and the request fields stable until that edge.
    // rsp_valid is a single-cycle pulse with no back-pressure. rsp_err and rsp_rdata
    // are meaningful only while rsp_valid is high.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data, mem_wren
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a 4K-word synchronous data memory.
// Define DMEM_LSU_SUBWORD_EN to enable byte/halfword access with read-modify-write stores.
module dmem_lsu (
    input  logic             clock,
    input  logic             reset_n,
    dmem_lsu_if.slave        bus,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
`ifdef DMEM_LSU_SUBWORD_EN
        MERGE = 3'd3,
`endif
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_e;

    state_e      state_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [11:0] mem_address_q;
    logic [31:0] mem_data_q;
    logic        mem_wren_q;
    logic        req_err_d;
    logic        unused_bits;

`ifdef DMEM_LSU_SUBWORD_EN
    logic        uns_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] wdata_q;
    logic [4:0]  lane_sh;
    logic [31:0] lane_mask;
    logic [31:0] load_sh;
    logic [31:0] load_ext_d;
    logic [31:0] merged_d;

    always_comb begin
        case (bus.req_size)
            2'b00:   req_err_d = 1'b0;
            2'b01:   req_err_d = bus.req_addr[0];
            2'b10:   req_err_d = |bus.req_addr[1:0];
            default: req_err_d = 1'b1;
        endcase
    end

    // Halfword accesses are 2-aligned, so a byte-granular shift serves both lane widths.
    always_comb begin
        lane_sh   = {addr_lo_q, 3'b000};
        lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        load_sh   = bus.mem_q >> lane_sh;
        case (size_q)
            2'b00:   load_ext_d = {{24{~uns_q & load_sh[7]}}, load_sh[7:0]};
            2'b01:   load_ext_d = {{16{~uns_q & load_sh[15]}}, load_sh[15:0]};
            default: load_ext_d = bus.mem_q;
        endcase
        merged_d = (bus.mem_q & ~(lane_mask << lane_sh)) | ((wdata_q & lane_mask) << lane_sh);
    end

    assign unused_bits = ^bus.req_addr[31:14];
`else
    always_comb begin
        req_err_d = (bus.req_size != 2'b10) || (|bus.req_addr[1:0]);
    end

    assign unused_bits = ^{bus.req_addr[31:14], bus.req_unsigned};
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            mem_address_q <= 12'h0;
            mem_data_q    <= 32'h0;
            mem_wren_q    <= 1'b0;
`ifdef DMEM_LSU_SUBWORD_EN
            uns_q         <= 1'b0;
            addr_lo_q     <= 2'b00;
            wdata_q       <= 32'h0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_wren_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q          <= bus.req_we;
                        size_q        <= bus.req_size;
                        mem_address_q <= bus.req_addr[13:2];
`ifdef DMEM_LSU_SUBWORD_EN
                        uns_q         <= bus.req_unsigned;
                        addr_lo_q     <= bus.req_addr[1:0];
                        wdata_q       <= bus.req_wdata;
`endif
                        if (req_err_d) begin
                            state_q     <= ERR;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            // Word stores write directly during ISSUE.
                            if (bus.req_we && bus.req_size == 2'b10) begin
                                mem_wren_q <= 1'b1;
                                mem_data_q <= bus.req_wdata;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (we_q && size_q == 2'b10) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
`ifdef DMEM_LSU_SUBWORD_EN
                    if (we_q) begin
                        state_q    <= MERGE;
                        mem_wren_q <= 1'b1;
                        mem_data_q <= merged_d;
                    end else begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_ext_d;
                    end
`else
                    state_q     <= DONE;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= bus.mem_q;
`endif
                end
`ifdef DMEM_LSU_SUBWORD_EN
                MERGE: begin
                    state_q     <= DONE;
                    rsp_valid_q <= 1'b1;
                end
`endif
                DONE:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gating with reset_n keeps a pending write from committing on a reset edge.
    assign bus.mem_wren    = mem_wren_q & reset_n;
    assign bus.req_ready   = (state_q == IDLE) & reset_n;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a synchronous memory model; covers both
// DMEM_LSU_SUBWORD_EN builds.
module tb_dmem_lsu;

    logic        clock;
    logic        reset_n;
    logic [2:0]  state;
    dmem_lsu_if  bus ();

    dmem_lsu dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .state_o (state)
    );

    int n_vec = 0;
    int n_err = 0;

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory model: read data valid the cycle after the address edge.
    logic [31:0] mem [0:4095];
    int          wren_cnt = 0;
    int          rsp_cnt = 0;
    logic [11:0] last_wr_addr = 12'h0;
    logic [31:0] last_wr_data = 32'h0;

    always @(posedge clock) begin
        if (bus.mem_wren === 1'b1) begin
            mem[bus.mem_address] <= bus.mem_data;
            wren_cnt             <= wren_cnt + 1;
            last_wr_addr         <= bus.mem_address;
            last_wr_data         <= bus.mem_data;
        end
        bus.mem_q <= mem[bus.mem_address];
        if (bus.rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
    end

    // Driver: one request from IDLE, then wait for its response.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output int wrs);
        int w0;
        @(negedge clock);
        n_vec++;
        if (bus.req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL req_ready_idle got %b want 1", bus.req_ready);
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        w0 = wren_cnt;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        lat   = 0;
        err   = 1'b0;
        rdata = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (bus.rsp_valid === 1'b1) begin
                lat   = i;
                err   = bus.rsp_err;
                rdata = bus.rsp_rdata;
                break;
            end
        end
        wrs = wren_cnt - w0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err got %b want 0", bus.rsp_err); end
        n_vec++; if (bus.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rsp_rdata got %h want 0", bus.rsp_rdata); end
        n_vec++; if (bus.mem_address !== 12'h0) begin n_err++; $display("FAIL rst_mem_address got %h want 0", bus.mem_address); end
        n_vec++; if (bus.mem_data !== 32'h0) begin n_err++; $display("FAIL rst_mem_data got %h want 0", bus.mem_data); end
        n_vec++; if (bus.mem_wren !== 1'b0) begin n_err++; $display("FAIL rst_mem_wren got %b want 0", bus.mem_wren); end
        n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready got %b want 0", bus.req_ready); end
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", state); end
        reset_n = 1'b1;
        @(negedge clock);
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rel_req_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_word();
        int lat, wrs; logic err; logic [31:0] rd;
        do_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, rd, wrs);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL wst_latency got %0d want 2", lat); end
        n_vec++; if (err !== 1'b0 || rd !== 32'h0) begin n_err++; $display("FAIL wst_rsp got err=%b rdata=%h want 0/0", err, rd); end
        n_vec++; if (wrs !== 1) begin n_err++; $display("FAIL wst_wren_cycles got %0d want 1", wrs); end
        n_vec++; if (last_wr_addr !== 12'd4) begin n_err++; $display("FAIL wst_addr got %h want 004", last_wr_addr); end
        n_vec++; if (mem[4] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wst_mem got %h want deadbeef", mem[4]); end
        do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, rd, wrs);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL wld_latency got %0d want 3", lat); end
        n_vec++; if (err !== 1'b0 || rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL wld_rsp got err=%b rdata=%h want 0/deadbeef", err, rd); end
        n_vec++; if (wrs !== 0) begin n_err++; $display("FAIL wld_wren_cycles got %0d want 0", wrs); end
        n_vec++; if (bus.mem_address !== 12'd4) begin n_err++; $display("FAIL wld_addr got %h want 004", bus.mem_address); end
        repeat (2) @(negedge clock);
        n_vec++; if (bus.mem_address !== 12'd4 || bus.mem_data !== 32'hDEADBEEF || bus.mem_wren !== 1'b0)
            begin n_err++; $display("FAIL idle_hold got addr=%h data=%h wren=%b want 004/deadbeef/0", bus.mem_address, bus.mem_data, bus.mem_wren); end
    endtask

    task automatic test_back_to_back();
        int lat, wrs; logic err; logic [31:0] rd;
        do_txn(1'b1, 2'b10, 1'b0, 32'h24, 32'hA5A50F0F, lat, err, rd, wrs);
        do_txn(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, lat, err, rd, wrs);
        n_vec++; if (lat !== 3 || rd !== 32'hA5A50F0F) begin n_err++; $display("FAIL b2b_load got lat=%0d rdata=%h want 3/a5a50f0f", lat, rd); end
        do_txn(1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_0000, lat, err, rd, wrs);
        do_txn(1'b0, 2'b10, 1'b0, 32'h20, 32'hFFFF_FFFF, lat, err, rd, wrs);
        n_vec++; if (lat !== 3 || rd !== 32'h0) begin n_err++; $display("FAIL b2b_zero got lat=%0d rdata=%h want 3/0", lat, rd); end
    endtask

    task automatic test_errors();
        int lat, wrs; logic err; logic [31:0] rd;
        logic [1:0]  sz [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] ad [3] = '{32'h13, 32'h12, 32'h10};
        for (int k = 0; k < 3; k++) begin
            do_txn(1'b0, sz[k], 1'b0, ad[k], 32'h0, lat, err, rd, wrs);
            n_vec++;
            if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wrs !== 0) begin
                n_err++;
                $display("FAIL err_case%0d got lat=%0d err=%b rdata=%h wr=%0d want 1/1/0/0", k, lat, err, rd, wrs);
            end
        end
        do_txn(1'b1, 2'b10, 1'b0, 32'h11, 32'h12345678, lat, err, rd, wrs);
        n_vec++; if (lat !== 1 || err !== 1'b1 || wrs !== 0 || mem[4] !== 32'hDEADBEEF)
            begin n_err++; $display("FAIL err_wst got lat=%0d err=%b wr=%0d mem=%h want 1/1/0/deadbeef", lat, err, wrs, mem[4]); end
    endtask

`ifdef DMEM_LSU_SUBWORD_EN
    task automatic test_subword();
        int lat, wrs; logic err; logic [31:0] rd;
        do_txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0080, lat, err, rd, wrs);
        n_vec++; if (lat !== 4 || err !== 1'b0 || wrs !== 1) begin n_err++; $display("FAIL sb_store got lat=%0d err=%b wr=%0d want 4/0/1", lat, err, wrs); end
        n_vec++; if (mem[4] !== 32'hDEAD80EF) begin n_err++; $display("FAIL sb_mem got %h want dead80ef", mem[4]); end
        do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, err, rd, wrs);
        n_vec++; if (rd !== 32'hDEAD80EF) begin n_err++; $display("FAIL sb_word got %h want dead80ef", rd); end
        do_txn(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, err, rd, wrs);
        n_vec++; if (lat !== 3 || rd !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_signed got lat=%0d rdata=%h want 3/ffffff80", lat, rd); end
        do_txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, err, rd, wrs);
        n_vec++; if (rd !== 32'h00000080) begin n_err++; $display("FAIL lb_unsigned got %h want 00000080", rd); end
        do_txn(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, err, rd, wrs);
        n_vec++; if (rd !== 32'hFFFFFFEF) begin n_err++; $display("FAIL lb_lane0 got %h want ffffffef", rd); end
        do_txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, err, rd, wrs);
        n_vec++; if (rd !== 32'hFFFFDEAD) begin n_err++; $display("FAIL lh_signed got %h want ffffdead", rd); end
        do_txn(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, err, rd, wrs);
        n_vec++; if (rd !== 32'h000080EF) begin n_err++; $display("FAIL lh_unsigned got %h want 000080ef", rd); end
        do_txn(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, lat, err, rd, wrs);
        n_vec++; if (lat !== 4 || mem[4] !== 32'h123480EF) begin n_err++; $display("FAIL sh_store got lat=%0d mem=%h want 4/123480ef", lat, mem[4]); end
    endtask

    task automatic test_reset_merge();
        int r0, w0;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h13; bus.req_wdata = 32'h55;
        r0 = rsp_cnt; w0 = wren_cnt;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++; if (wren_cnt - w0 !== 0 || mem[4] !== 32'h123480EF)
            begin n_err++; $display("FAIL rst_merge_write got wr=%0d mem=%h want 0/123480ef", wren_cnt - w0, mem[4]); end
        n_vec++; if (rsp_cnt - r0 !== 0) begin n_err++; $display("FAIL rst_merge_rsp got %0d want 0", rsp_cnt - r0); end
    endtask
`else
    task automatic test_subword_off();
        int lat, wrs; logic err; logic [31:0] rd;
        do_txn(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0080, lat, err, rd, wrs);
        n_vec++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wrs !== 0)
            begin n_err++; $display("FAIL sb_off got lat=%0d err=%b rdata=%h wr=%0d want 1/1/0/0", lat, err, rd, wrs); end
        n_vec++; if (mem[4] !== 32'hDEADBEEF) begin n_err++; $display("FAIL sb_off_mem got %h want deadbeef", mem[4]); end
        do_txn(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, lat, err, rd, wrs);
        n_vec++; if (lat !== 1 || err !== 1'b1) begin n_err++; $display("FAIL lh_off got lat=%0d err=%b want 1/1", lat, err); end
    endtask
`endif

    task automatic test_high_addr();
        int lat, wrs; logic err; logic [31:0] rd;
        logic [31:0] exp_w;
`ifdef DMEM_LSU_SUBWORD_EN
        exp_w = 32'h123480EF;
`else
        exp_w = 32'hDEADBEEF;
`endif
        do_txn(1'b0, 2'b10, 1'b0, 32'hFFFF_C010, 32'h0, lat, err, rd, wrs);
        n_vec++; if (bus.mem_address !== 12'd4 || rd !== exp_w)
            begin n_err++; $display("FAIL high_addr got addr=%h rdata=%h want 004/%h", bus.mem_address, rd, exp_w); end
    endtask

    task automatic test_reset_word_store();
        int r0, w0;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFEF00D;
        r0 = rsp_cnt; w0 = wren_cnt;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_vec++; if (wren_cnt - w0 !== 0 || mem[8] !== 32'h0)
            begin n_err++; $display("FAIL rst_wst_write got wr=%0d mem=%h want 0/0", wren_cnt - w0, mem[8]); end
        n_vec++; if (rsp_cnt - r0 !== 0) begin n_err++; $display("FAIL rst_wst_rsp got %0d want 0", rsp_cnt - r0); end
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_wst_ready got %b want 1", bus.req_ready); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_back_to_back();
        test_errors();
`ifdef DMEM_LSU_SUBWORD_EN
        test_subword();
        test_high_addr();
        test_reset_merge();
`else
        test_subword_off();
        test_high_addr();
`endif
        test_reset_word_store();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
